imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the pipelined core's decode stage. It covers every RV32I/RV64I immediate format (I, S, B, U, J), plus shift-amount extraction and an illegal-opcode flag. A valid/ready handshake with a two-entry skid buffer sustains one instruction per cycle under backpressure. A sideband tag (PC, rd, etc.) travels alongside each instruction.

Parameters:
XLEN, 32, datapath width; legal values 32 and 64 only.
TAG_W, 32, sideband tag width carried unchanged; must be at least 1.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; drops every held entry
in_valid  in  1  instruction offered
in_ready  out  1  block can accept this cycle
in_inst  in  32  instruction word
in_tag  in  TAG_W  sideband
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_imm  out  XLEN  sign/zero-extended immediate
out_fmt  out  3  format code (imm_gen_pkg)
out_illegal  out  1  opcode not recognised
out_tag  out  TAG_W  sideband of the same instruction

Behaviour:
- Reset: clk single clock; rst_n asynchronous assert, synchronous deassert. While rst_n=0: out_valid=0, in_ready=0, out_imm=0, out_fmt=FMT_R, out_illegal=0, out_tag=0, both buffer entries invalid. in_ready rises the first cycle after deassertion. Reset mid-transfer discards all entries.
- Handshake: a transfer occurs when valid&ready are high at a rising edge. in_ready is a register equal to "skid entry empty"; it does not depend combinationally on out_ready. out_valid is held, with stable data, until accepted.
- Latency: 1 cycle. An instruction accepted at edge N appears at the outputs after edge N with out_valid=1. Throughput is 1 per cycle while out_ready=1.
- Skid buffer: main register M drives the outputs; skid register S is the overflow entry.
  - Accept while M is empty, or while M is drained the same cycle: load M.
  - Accept while M is full and out_ready=0: load S; in_ready drops next cycle.
  - M drained while S is full: S moves to M, S empties, in_ready rises next cycle.
  - Ordering is strictly FIFO. No drops or duplicates.
- flush: takes priority over any same-cycle accept. Next cycle out_valid=0, S is empty and in_ready=1. An input presented in the flush cycle is discarded.
- Decode, on opcode inst[6:0]. All results are sign-extended to XLEN from inst[31] unless stated otherwise:
  - 0010011 OP-IMM: I. If funct3 is 001 or 101, imm is the zero-extended shamt: inst[24:20] when XLEN=32, inst[25:20] when XLEN=64.
  - 0011011 OP-IMM-32, XLEN=64 only: as OP-IMM with a 5-bit shamt. Illegal when XLEN=32.
  - 0000011 LOAD, 1100111 JALR, 1110011 SYSTEM: I, imm = inst[31:20].
  - 0100011 STORE: S, imm = {inst[31:25], inst[11:7]}.
  - 1100011 BRANCH: B, imm = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - 0110111 LUI, 0010111 AUIPC: U, imm = {inst[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64.
  - 1101111 JAL: J, imm = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - 0110011 OP, 0111011 OP-32 (XLEN=64 only): R, imm=0.
  - 0001111 MISC-MEM: I, imm = inst[31:20].
  - Any other opcode: fmt=FMT_ILL, out_illegal=1, imm=0. The instruction still flows through the pipeline normally.
- Decode is combinational ahead of the registers; only decoded values are stored, never raw instruction bits.

Decomposition:
- imm_gen_pkg holds the FMT_R=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5, FMT_ILL=7 codes and the opcode constants (OPC_OP_IMM, OPC_LOAD, ...).
- Sub-module imm_decode is the pure combinational decoder (inst → imm, fmt, illegal, parametrised on XLEN), reusable by the single-cycle core.
- The top level holds the skid-buffer control and registers.

Test Plan:
- XLEN=32, out_ready=1: send 0xFFF00093, 0x0020A423, 0xFE000EE3, 0x123452B7, 0x001000EF back-to-back. Required results, one per cycle, each one cycle after its accept: imm 0xFFFFFFFF/I, 0x00000008/S, 0xFFFFFFFC/B, 0x12345000/U, 0x00000800/J.
- Shift immediate: 0x4030D093 (srai x1,x1,3) → imm 0x00000003, fmt I. Also 0x00000000 → out_illegal=1, imm 0, fmt 7.
- Backpressure: hold out_ready=0, send tags 1, 2, 3 back-to-back. Tag 1 is held in M and tag 2 in S; in_ready=0 so tag 3 is stalled. Raise out_ready: tags 1, 2, 3 emerge in order with no bubble once tag 3 is accepted.
- Flush with M and S full and in_valid=1 → out_valid=0 and in_ready=1 next cycle. None of the three instructions ever appear.
- XLEN=64: 0x800002B7 (lui) → 0xFFFFFFFF80000000. 0x03F09093 (slli x1,x1,63) → imm 63. 0x0000501B with XLEN=32 → illegal.
- Assert rst_n low mid-stream with S full → outputs go to reset values immediately (asynchronously). After release, the first new instruction emerges with correct data and tag.

Source files
------------

// File: rtl/imm_gen_pkg.sv
// Shared format codes and RV32I/RV64I opcode constants for the immediate
// generator and any core stage that reuses the decoder.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle. The slave side is the
// immediate generator; the master side is the surrounding pipeline.
interface imm_gen_pipe_if import imm_gen_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_decode.sv
// Pure combinational immediate decoder: instruction word -> extended
// immediate, format code and illegal flag. Shared with the single-cycle core.
module imm_decode import imm_gen_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm,
  output fmt_e            o_fmt,
  output logic            o_illegal
);
  localparam bit RV64 = (XLEN == 64);

  logic signed [31:0] w_i, w_s, w_b, w_u, w_j;
  logic        [5:0]  w_sh;
  logic               w_shift;

  // Every format is built as a signed 32-bit value; the size cast below
  // then sign-extends to XLEN for free.
  assign w_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign w_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign w_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign w_u = {i_inst[31:12], 12'b0};
  assign w_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  assign w_sh    = RV64 ? i_inst[25:20] : {1'b0, i_inst[24:20]};
  assign w_shift = (i_inst[14:12] == 3'b001) || (i_inst[14:12] == 3'b101);

  always_comb begin
    o_imm     = '0;
    o_fmt     = FMT_ILL;
    o_illegal = 1'b1;
    case (i_inst[6:0])
      OPC_OP_IMM: begin
        o_fmt = FMT_I; o_illegal = 1'b0;
        o_imm = w_shift ? XLEN'(w_sh) : XLEN'(w_i);
      end
      OPC_OP_IMM_32: if (RV64) begin
        o_fmt = FMT_I; o_illegal = 1'b0;
        o_imm = w_shift ? XLEN'(w_sh[4:0]) : XLEN'(w_i);
      end
      OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: begin
        o_fmt = FMT_I; o_illegal = 1'b0; o_imm = XLEN'(w_i);
      end
      OPC_STORE: begin
        o_fmt = FMT_S; o_illegal = 1'b0; o_imm = XLEN'(w_s);
      end
      OPC_BRANCH: begin
        o_fmt = FMT_B; o_illegal = 1'b0; o_imm = XLEN'(w_b);
      end
      OPC_LUI, OPC_AUIPC: begin
        o_fmt = FMT_U; o_illegal = 1'b0; o_imm = XLEN'(w_u);
      end
      OPC_JAL: begin
        o_fmt = FMT_J; o_illegal = 1'b0; o_imm = XLEN'(w_j);
      end
      OPC_OP: begin
        o_fmt = FMT_R; o_illegal = 1'b0;
      end
      OPC_OP_32: if (RV64) begin
        o_fmt = FMT_R; o_illegal = 1'b0;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage: decoder in front of a
// two-entry skid buffer (M drives the outputs, S absorbs one stalled beat).
module imm_gen_pipe import imm_gen_pkg::*; #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);
  logic [XLEN-1:0]  w_imm;
  fmt_e             w_fmt;
  logic             w_ill;

  logic             r_m_vld, r_s_vld, r_in_ready;
  logic [XLEN-1:0]  r_m_imm, r_s_imm;
  fmt_e             r_m_fmt, r_s_fmt;
  logic             r_m_ill, r_s_ill;
  logic [TAG_W-1:0] r_m_tag, r_s_tag;

  logic w_acc, w_m_free;
  logic w_ld_m_in, w_ld_m_s, w_ld_s;
  logic w_m_vld_nx, w_s_vld_nx;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .i_inst    (bus.in_inst),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_ill)
  );

  assign w_acc    = bus.in_valid & r_in_ready;
  assign w_m_free = ~r_m_vld | bus.out_ready;

  // S is only ever full while in_ready is low, so S->M and an accept
  // never compete for M in the same cycle.
  always_comb begin
    w_ld_m_in  = 1'b0;
    w_ld_m_s   = 1'b0;
    w_ld_s     = 1'b0;
    w_m_vld_nx = r_m_vld;
    w_s_vld_nx = r_s_vld;
    if (flush) begin
      w_m_vld_nx = 1'b0;
      w_s_vld_nx = 1'b0;
    end else if (w_m_free) begin
      if (r_s_vld) begin
        w_ld_m_s   = 1'b1;
        w_m_vld_nx = 1'b1;
        w_s_vld_nx = 1'b0;
      end else begin
        w_ld_m_in  = w_acc;
        w_m_vld_nx = w_acc;
      end
    end else if (w_acc) begin
      w_ld_s     = 1'b1;
      w_s_vld_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_vld    <= 1'b0;
      r_s_vld    <= 1'b0;
      r_in_ready <= 1'b0;
      r_m_imm    <= '0;
      r_m_fmt    <= FMT_R;
      r_m_ill    <= 1'b0;
      r_m_tag    <= '0;
      r_s_imm    <= '0;
      r_s_fmt    <= FMT_R;
      r_s_ill    <= 1'b0;
      r_s_tag    <= '0;
    end else begin
      r_m_vld    <= w_m_vld_nx;
      r_s_vld    <= w_s_vld_nx;
      r_in_ready <= ~w_s_vld_nx;
      if (w_ld_m_in) begin
        r_m_imm <= w_imm; r_m_fmt <= w_fmt; r_m_ill <= w_ill; r_m_tag <= bus.in_tag;
      end else if (w_ld_m_s) begin
        r_m_imm <= r_s_imm; r_m_fmt <= r_s_fmt; r_m_ill <= r_s_ill; r_m_tag <= r_s_tag;
      end
      if (w_ld_s) begin
        r_s_imm <= w_imm; r_s_fmt <= w_fmt; r_s_ill <= w_ill; r_s_tag <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_m_vld;
  assign bus.out_imm     = r_m_imm;
  assign bus.out_fmt     = r_m_fmt;
  assign bus.out_illegal = r_m_ill;
  assign bus.out_tag     = r_m_tag;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: decode table on XLEN=32 and XLEN=64 instances sharing one
// stimulus stream, plus backpressure, flush and mid-stream reset sequences.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  localparam int NV = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   n_pass, n_tot;
  vec_t vt[NV];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b64.in_valid  = b32.in_valid;
  assign b64.in_inst   = b32.in_inst;
  assign b64.in_tag    = b32.in_tag;
  assign b64.out_ready = b32.out_ready;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b64));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] tag);
    b32.in_valid = 1'b1;
    b32.in_inst  = inst;
    b32.in_tag   = tag;
  endtask

  initial begin
    n_pass = 0; n_tot = 0;
    rst_n = 1'b0; flush = 1'b0;
    b32.in_valid = 1'b0; b32.in_inst = '0; b32.in_tag = '0; b32.out_ready = 1'b0;

    //         inst          imm32         f  il  imm64                  f  il
    vt[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 1, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0};
    vt[1]  = '{32'h0020A423, 32'h00000008, 2, 0, 64'h0000000000000008, 2, 0};
    vt[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3, 0, 64'hFFFFFFFFFFFFFFFC, 3, 0};
    vt[3]  = '{32'h123452B7, 32'h12345000, 4, 0, 64'h0000000012345000, 4, 0};
    vt[4]  = '{32'h001000EF, 32'h00000800, 5, 0, 64'h0000000000000800, 5, 0};
    vt[5]  = '{32'h4030D093, 32'h00000003, 1, 0, 64'h0000000000000003, 1, 0};
    vt[6]  = '{32'h00000000, 32'h00000000, 7, 1, 64'h0000000000000000, 7, 1};
    vt[7]  = '{32'h800002B7, 32'h80000000, 4, 0, 64'hFFFFFFFF80000000, 4, 0};
    vt[8]  = '{32'h03F09093, 32'h0000001F, 1, 0, 64'h000000000000003F, 1, 0};
    vt[9]  = '{32'h0000501B, 32'h00000000, 7, 1, 64'h0000000000000000, 1, 0};
    vt[10] = '{32'h00B5053B, 32'h00000000, 7, 1, 64'h0000000000000000, 0, 0};
    vt[11] = '{32'h00B50533, 32'h00000000, 0, 0, 64'h0000000000000000, 0, 0};
    vt[12] = '{32'hFFFFF517, 32'hFFFFF000, 4, 0, 64'hFFFFFFFFFFFFF000, 4, 0};
    vt[13] = '{32'h800080E7, 32'hFFFFF800, 1, 0, 64'hFFFFFFFFFFFFF800, 1, 0};
    vt[14] = '{32'h0FF0000F, 32'h000000FF, 1, 0, 64'h00000000000000FF, 1, 0};
    vt[15] = '{32'h00100073, 32'h00000001, 1, 0, 64'h0000000000000001, 1, 0};
    vt[16] = '{32'h7FF02083, 32'h000007FF, 1, 0, 64'h00000000000007FF, 1, 0};
    vt[17] = '{32'hFE9FF06F, 32'hFFFFFFE8, 5, 0, 64'hFFFFFFFFFFFFFFE8, 5, 0};
    vt[18] = '{32'hFE112E23, 32'hFFFFFFFC, 2, 0, 64'hFFFFFFFFFFFFFFFC, 2, 0};
    vt[19] = '{32'h0250D093, 32'h00000005, 1, 0, 64'h0000000000000025, 1, 0};

    // Reset values
    #2;
    chk("rst out_valid", b32.out_valid, 0);
    chk("rst in_ready", b32.in_ready, 0);
    chk("rst out_imm", b32.out_imm, 0);
    chk("rst out_fmt", b32.out_fmt, 0);
    chk("rst out_illegal", b32.out_illegal, 0);
    chk("rst out_tag", b32.out_tag, 0);
    chk("rst out_valid64", b64.out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("in_ready held until edge", b32.in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready after reset", b32.in_ready, 1);

    // Decode table, back to back with out_ready high
    @(negedge clk);
    b32.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      if (i != 0) @(negedge clk);
      offer(vt[i].inst, 32'(100 + i));
      @(posedge clk); #1;
      chk($sformatf("v%0d valid", i),   b32.out_valid,   1);
      chk($sformatf("v%0d imm32", i),   b32.out_imm,     vt[i].imm32);
      chk($sformatf("v%0d fmt32", i),   b32.out_fmt,     vt[i].fmt32);
      chk($sformatf("v%0d ill32", i),   b32.out_illegal, vt[i].ill32);
      chk($sformatf("v%0d tag32", i),   b32.out_tag,     100 + i);
      chk($sformatf("v%0d imm64", i),   b64.out_imm,     vt[i].imm64);
      chk($sformatf("v%0d fmt64", i),   b64.out_fmt,     vt[i].fmt64);
      chk($sformatf("v%0d ill64", i),   b64.out_illegal, vt[i].ill64);
      chk($sformatf("v%0d tag64", i),   b64.out_tag,     100 + i);
      chk($sformatf("v%0d in_ready", i), b32.in_ready,   1);
    end
    @(negedge clk); b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain out_valid", b32.out_valid, 0);

    // Backpressure: tag1 in M, tag2 in S, tag3 stalled
    @(negedge clk); b32.out_ready = 1'b0; offer(32'h123452B7, 1);
    @(posedge clk); #1;
    chk("bp t1 tag", b32.out_tag, 1);
    chk("bp t1 in_ready", b32.in_ready, 1);
    @(negedge clk); offer(32'h0020A423, 2);
    @(posedge clk); #1;
    chk("bp t2 hold tag", b32.out_tag, 1);
    chk("bp t2 in_ready", b32.in_ready, 0);
    @(negedge clk); offer(32'hFE000EE3, 3);
    @(posedge clk); #1;
    chk("bp stall valid", b32.out_valid, 1);
    chk("bp stall tag", b32.out_tag, 1);
    chk("bp stall imm", b32.out_imm, 32'h12345000);
    chk("bp stall in_ready", b32.in_ready, 0);
    @(negedge clk); b32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp s2m tag", b32.out_tag, 2);
    chk("bp s2m imm", b32.out_imm, 32'h00000008);
    chk("bp s2m in_ready", b32.in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("bp t3 valid", b32.out_valid, 1);
    chk("bp t3 tag", b32.out_tag, 3);
    chk("bp t3 imm", b32.out_imm, 32'hFFFFFFFC);
    @(negedge clk); b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp empty", b32.out_valid, 0);

    // Flush with M and S full and a third beat offered
    @(negedge clk); b32.out_ready = 1'b0; offer(32'hFFF00093, 11);
    @(posedge clk);
    @(negedge clk); offer(32'h0020A423, 12);
    @(posedge clk); #1;
    chk("fl full in_ready", b32.in_ready, 0);
    @(negedge clk); offer(32'h001000EF, 13); flush = 1'b1;
    @(posedge clk); #1;
    chk("fl out_valid", b32.out_valid, 0);
    chk("fl in_ready", b32.in_ready, 1);
    chk("fl out_valid64", b64.out_valid, 0);
    @(negedge clk); flush = 1'b0; b32.in_valid = 1'b0; b32.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("fl quiet%0d", c), b32.out_valid, 0);
    end

    // Asynchronous reset with S full
    @(negedge clk); b32.out_ready = 1'b0; offer(32'h123452B7, 21);
    @(posedge clk);
    @(negedge clk); offer(32'h0020A423, 22);
    @(posedge clk); #1;
    chk("ar full in_ready", b32.in_ready, 0);
    @(negedge clk); b32.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar out_valid", b32.out_valid, 0);
    chk("ar in_ready", b32.in_ready, 0);
    chk("ar out_tag", b32.out_tag, 0);
    chk("ar out_imm", b32.out_imm, 0);
    chk("ar out_fmt", b32.out_fmt, 0);
    @(negedge clk); rst_n = 1'b1; b32.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("ar post valid", b32.out_valid, 0);
    chk("ar post in_ready", b32.in_ready, 1);
    @(negedge clk); offer(32'hFFF00093, 31);
    @(posedge clk); #1;
    chk("ar new valid", b32.out_valid, 1);
    chk("ar new tag", b32.out_tag, 31);
    chk("ar new imm", b32.out_imm, 32'hFFFFFFFF);
    chk("ar new fmt", b32.out_fmt, 1);
    chk("ar new imm64", b64.out_imm, 64'hFFFFFFFFFFFFFFFF);
    @(negedge clk); b32.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ar end empty", b32.out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
